// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-address generator with exception/eret redirect,
// hazard stall, delayed-branch redirect and an accepted-fetch counter.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] EXC_PC   = 32'h0000_4180,
    parameter logic [31:0] IM_LO    = 32'h0000_3000,
    parameter logic [31:0] IM_HI    = 32'h0000_6FFC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        br_valid,
    input  logic [31:0] br_target,
    input  logic        exc_req,
    input  logic        eret_req,
    input  logic [31:0] epc,
    output logic [31:0] pc,
    output logic        pc_valid,
    output logic        fetch_adel,
    output logic [31:0] fetch_cnt
);

    typedef enum logic [1:0] {BOOT, RUN, HOLD, REDIR} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] cnt_q, cnt_d;
    logic        valid_q, valid_d;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        if (exc_req) begin
            pc_d    = EXC_PC;
            state_d = REDIR;
        end else if (eret_req) begin
            pc_d    = epc;
            state_d = REDIR;
        end else if (stall) begin
            // BOOT/REDIR keep waiting: their address has not been fetched yet
            if (state_q == RUN) state_d = HOLD;
        end else begin
            state_d = RUN;
            if (valid_q) pc_d = br_valid ? br_target : pc_q + 32'd4;
        end
        valid_d = (state_d == RUN) || (state_d == HOLD);
        cnt_d   = (valid_q && !stall) ? cnt_q + 32'd1 : cnt_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            valid_q <= 1'b0;
            cnt_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign pc         = pc_q;
    assign pc_valid   = valid_q;
    assign fetch_cnt  = cnt_q;
    assign fetch_adel = valid_q &&
                        ((pc_q[1:0] != 2'b00) || (pc_q < IM_LO) || (pc_q > IM_HI));

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios with literal expectations
// plus randomized traffic checked against a behavioural fetch model.
module tb_pc_sequencer;

    localparam logic [31:0] RST_PC = 32'h0000_3000;
    localparam logic [31:0] EXC    = 32'h0000_4180;
    localparam logic [31:0] LO     = 32'h0000_3000;
    localparam logic [31:0] HI     = 32'h0000_6FFC;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        br_valid = 1'b0;
    logic [31:0] br_target = 32'd0;
    logic        exc_req = 1'b0;
    logic        eret_req = 1'b0;
    logic [31:0] epc = 32'd0;
    logic [31:0] pc;
    logic        pc_valid;
    logic        fetch_adel;
    logic [31:0] fetch_cnt;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    pc_sequencer dut (
        .clk(clk), .reset(reset), .stall(stall),
        .br_valid(br_valid), .br_target(br_target),
        .exc_req(exc_req), .eret_req(eret_req), .epc(epc),
        .pc(pc), .pc_valid(pc_valid),
        .fetch_adel(fetch_adel), .fetch_cnt(fetch_cnt)
    );

    always #5 clk = ~clk;

    // Model: an address is either waiting to be fetched (live=0) or being
    // fetched (live=1); an accepted fetch moves on to pc+4 or the branch.
    logic [31:0] m_pc = RST_PC;
    bit          m_live = 1'b0;
    logic [31:0] m_cnt = 32'd0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_pc = RST_PC;
            m_live = 1'b0;
            m_cnt = 32'd0;
        end else begin
            if (m_live && !stall) m_cnt = m_cnt + 1;
            if (exc_req) begin
                m_pc = EXC;
                m_live = 1'b0;
            end else if (eret_req) begin
                m_pc = epc;
                m_live = 1'b0;
            end else if (!stall) begin
                if (m_live) m_pc = br_valid ? br_target : m_pc + 4;
                m_live = 1'b1;
            end
        end
    end

    function automatic bit m_adel();
        return m_live && ((m_pc % 4 != 0) || (m_pc < LO) || (m_pc > HI));
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_pc", pc, m_pc);
            check("model_valid", {31'd0, pc_valid}, {31'd0, m_live});
            check("model_adel", {31'd0, fetch_adel}, {31'd0, m_adel()});
            check("model_cnt", fetch_cnt, m_cnt);
        end
    end

    task automatic cyc(input bit s, input bit b, input logic [31:0] bt,
                       input bit e, input bit r, input logic [31:0] ep);
        stall = s;
        br_valid = b;
        br_target = bt;
        exc_req = e;
        eret_req = r;
        epc = ep;
        @(negedge clk);
        #1;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        #1;
        check("rst_pc", pc, 32'h3000);
        check("rst_valid", {31'd0, pc_valid}, 32'd0);
        check("rst_cnt", fetch_cnt, 32'd0);
        check("rst_adel", {31'd0, fetch_adel}, 32'd0);
        reset = 1'b0;
        chk_en = 1'b1;
        #1;
        check("boot_valid", {31'd0, pc_valid}, 32'd0);
        cyc(0, 0, 0, 0, 0, 0);
        check("first_pc", pc, 32'h3000);
        check("first_valid", {31'd0, pc_valid}, 32'd1);
        cyc(0, 0, 0, 0, 0, 0);
        check("seq_pc", pc, 32'h3004);
        cyc(0, 0, 0, 0, 0, 0);
        check("cnt_two", fetch_cnt, 32'd2);
        check("pc_3008", pc, 32'h3008);
        cyc(0, 1, 32'h3100, 0, 0, 0);
        check("br_pc", pc, 32'h3100);
        check("br_valid_kept", {31'd0, pc_valid}, 32'd1);
        cyc(0, 1, 32'h300C, 0, 0, 0);
        check("br_back", pc, 32'h300C);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 1, 32'h3200, 0, 0, 0);
            check("stall_pc", pc, 32'h300C);
            check("stall_cnt", fetch_cnt, 32'd4);
        end
        cyc(0, 1, 32'h3200, 0, 0, 0);
        check("unstall_br", pc, 32'h3200);
        cyc(0, 1, 32'h3010, 0, 0, 0);
        cyc(1, 0, 0, 1, 0, 0);
        check("exc_pc", pc, 32'h4180);
        check("exc_invalid", {31'd0, pc_valid}, 32'd0);
        cyc(0, 0, 0, 0, 0, 0);
        check("exc_fetch", pc, 32'h4180);
        check("exc_fetch_v", {31'd0, pc_valid}, 32'd1);
        cyc(0, 0, 0, 0, 1, 32'h3016);
        check("eret_pc", pc, 32'h3016);
        check("eret_adel_inv", {31'd0, fetch_adel}, 32'd0);
        cyc(0, 0, 0, 0, 0, 0);
        check("adel_misal", {31'd0, fetch_adel}, 32'd1);
        cyc(0, 0, 0, 0, 1, 32'h7000);
        cyc(0, 0, 0, 0, 0, 0);
        check("adel_range", {31'd0, fetch_adel}, 32'd1);
        cyc(0, 1, 32'h3300, 1, 1, 32'h3000);
        check("exc_over_eret", pc, 32'h4180);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        check("hold_pc", pc, 32'h4180);
        #1 reset = 1'b1;
        #1;
        check("async_pc", pc, 32'h3000);
        check("async_valid", {31'd0, pc_valid}, 32'd0);
        check("async_cnt", fetch_cnt, 32'd0);
        reset = 1'b0;
        cyc(1, 0, 0, 0, 0, 0);
        check("boot_stall", {31'd0, pc_valid}, 32'd0);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        force dut.cnt_q = 32'hFFFF_FFFF;
        m_cnt = 32'hFFFF_FFFF;
        #1 release dut.cnt_q;
        check("cnt_max", fetch_cnt, 32'hFFFF_FFFF);
        cyc(0, 0, 0, 0, 0, 0);
        check("cnt_wrap", fetch_cnt, 32'd0);

        for (int i = 0; i < 3000; i++) begin
            logic [31:0] bt, ep;
            bt = {$urandom_range(32'h0C00, 32'h1C00), 2'b00};
            if ($urandom_range(0, 9) == 0) bt = $urandom;
            ep = {$urandom_range(32'h0C00, 32'h1C00), 2'b00};
            if ($urandom_range(0, 3) == 0) ep = ep + $urandom_range(0, 3);
            cyc($urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0, bt,
                $urandom_range(0, 19) == 0, $urandom_range(0, 19) == 0, ep);
            if ($urandom_range(0, 199) == 0) begin
                #1 reset = 1'b1;
                #1 reset = 1'b0;
            end
        end
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
